clk_divider_multi: RTL

Parametrised multi-channel clock divider. It generates CHANNELS independent divided clocks from one system clock, with one tick strobe per channel. Each channel has its own runtime division ratio and enable. A ratio change takes effect only at a period boundary, so the output never glitches. The block sits next to the top level and supplies the slow clocks and strobes for game timing, display refresh and debouncing.

---
 rtl/clk_divider_multi.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/clk_divider_multi.sv
// -----------------------------------------------------------------------------
// clk_divider_multi
//
// Multi-channel clock divider. Each of the CHANNELS channels divides the system
// clock by its own runtime ratio R, producing a registered divided clock that
// toggles once every R cycles (f_out = f_clk / (2*R)) and a one-cycle tick
// strobe on the cycle after every period boundary.
//
// A new ratio is only adopted at a period boundary (or while a channel is
// idle), so a running channel always finishes its current period with the old
// ratio and its divided clock never glitches. A ratio of 0 parks a channel.
//
// Ports:
//   i_clk        system clock, all logic on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_div_ratio  requested ratios, channel k at [k*WIDTH +: WIDTH]
//   i_enable     per-channel run enable
//   i_sync       synchronous restart of every channel (phase alignment)
//   o_slow_clk   per-channel divided clock (registered)
//   o_tick       per-channel one-cycle period strobe (registered)
// -----------------------------------------------------------------------------
module clk_divider_multi #(
    parameter int CHANNELS = 4,
    parameter int WIDTH    = 24
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [CHANNELS*WIDTH-1:0] i_div_ratio,
    input  logic [CHANNELS-1:0]       i_enable,
    input  logic                      i_sync,
    output logic [CHANNELS-1:0]       o_slow_clk,
    output logic [CHANNELS-1:0]       o_tick
);

    // Channel operating states. A channel is not a stored FSM: its state is
    // derived each cycle from the enable and the active ratio.
    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_RUN  = 1'b1;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};

    genvar k;
    generate
        for (k = 0; k < CHANNELS; k = k + 1) begin : g_ch
            // Channel state
            logic [WIDTH-1:0] counter_r;
            logic [WIDTH-1:0] act_r;
            logic             slow_r;
            logic             tick_r;

            // Next-state and helper signals
            logic [WIDTH-1:0] ratio_s;
            logic [WIDTH-1:0] last_s;
            logic [WIDTH-1:0] counter_nxt_s;
            logic [WIDTH-1:0] act_nxt_s;
            logic             slow_nxt_s;
            logic             tick_nxt_s;
            logic             wrap_s;
            logic [0:0]       state_s;

            assign ratio_s = i_div_ratio[k*WIDTH +: WIDTH];

            // last_s is only consulted in RUN, where act_r is at least 1, so
            // the subtraction cannot underflow in any case that matters.
            assign last_s = act_r - ONE_W;
            assign wrap_s = (counter_r == last_s);

            // Derive the channel state from enable and the active ratio.
            always_comb begin
                if (i_enable[k] && (act_r != ZERO_W)) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end

            // Next-state logic: sync restart overrides the run/idle behaviour.
            always_comb begin
                counter_nxt_s = counter_r;
                act_nxt_s     = act_r;
                slow_nxt_s    = slow_r;
                tick_nxt_s    = 1'b0;
                if (i_sync) begin
                    counter_nxt_s = ZERO_W;
                    act_nxt_s     = ratio_s;
                    slow_nxt_s    = 1'b0;
                    tick_nxt_s    = 1'b0;
                end else begin
                    case (state_s)
                        ST_IDLE: begin
                            // Parked: keep tracking the requested ratio so a
                            // later enable starts a full period immediately.
                            counter_nxt_s = ZERO_W;
                            act_nxt_s     = ratio_s;
                            slow_nxt_s    = slow_r;
                            tick_nxt_s    = 1'b0;
                        end
                        ST_RUN: begin
                            if (wrap_s) begin
                                // Period boundary: the only point where a
                                // running channel may pick up a new ratio.
                                counter_nxt_s = ZERO_W;
                                act_nxt_s     = ratio_s;
                                slow_nxt_s    = ~slow_r;
                                tick_nxt_s    = 1'b1;
                            end else begin
                                counter_nxt_s = counter_r + ONE_W;
                                act_nxt_s     = act_r;
                                slow_nxt_s    = slow_r;
                                tick_nxt_s    = 1'b0;
                            end
                        end
                        default: begin
                            counter_nxt_s = ZERO_W;
                            act_nxt_s     = ratio_s;
                            slow_nxt_s    = slow_r;
                            tick_nxt_s    = 1'b0;
                        end
                    endcase
                end
            end

            // Channel registers with asynchronous clear.
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    counter_r <= ZERO_W;
                    act_r     <= ZERO_W;
                    slow_r    <= 1'b0;
                    tick_r    <= 1'b0;
                end else begin
                    counter_r <= counter_nxt_s;
                    act_r     <= act_nxt_s;
                    slow_r    <= slow_nxt_s;
                    tick_r    <= tick_nxt_s;
                end
            end

            assign o_slow_clk[k] = slow_r;
            assign o_tick[k]     = tick_r;
        end
    endgenerate

endmodule
